// File: rtl/gsm_at_pkg.sv
// Shared types, segment lengths and message strings for the GSM AT-command sequencer.
// Strings are stored without their terminators; msg_byte appends CR LF or Ctrl-Z.
package gsm_at_pkg;

  typedef enum logic [2:0] {
    SEG_AT,
    SEG_CMGF,
    SEG_CSMP,
    SEG_CSCS,
    SEG_CMGS,
    SEG_TEXT
  } seg_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEND,
    ST_WAIT_DONE,
    ST_BYTE_GAP,
    ST_CMD_GAP,
    ST_FINISH
  } state_e;

  localparam int IDX_W = 6;

  localparam int LEN_AT   = 4;
  localparam int LEN_CMGF = 11;
  localparam int LEN_CSMP = 21;
  localparam int LEN_CSCS = 16;
  localparam int LEN_CMGS = 56;
  localparam int LEN_TEXT = 41;

  localparam logic [8*2-1:0]  STR_AT   = "AT";
  localparam logic [8*9-1:0]  STR_CMGF = "AT+CMGF=1";
  localparam logic [8*19-1:0] STR_CSMP = "AT+CSMP=17,167,0,16";
  localparam logic [8*14-1:0] STR_CSCS = "AT+CSCS=\"UCS2\"";
  // Destination +4917012345 in UCS2 hex, matching the CSCS character set
  localparam logic [8*54-1:0] STR_CMGS =
    "AT+CMGS=\"002B0034003900310037003000310032003300340035\"";
  localparam logic [8*40-1:0] STR_TEXT0 = "ALARM SRC0 INTRUSION DETECTED AT ZONE 01";
  localparam logic [8*40-1:0] STR_TEXT1 = "ALARM SRC1 SMOKE SENSOR TRIGGERED ZONE 2";
  localparam logic [8*40-1:0] STR_TEXT2 = "ALARM SRC2 WATER LEAK DETECTED IN ZONE 3";

  function automatic int seg_len(input seg_e seg);
    case (seg)
      SEG_AT:   return LEN_AT;
      SEG_CMGF: return LEN_CMGF;
      SEG_CSMP: return LEN_CSMP;
      SEG_CSCS: return LEN_CSCS;
      SEG_CMGS: return LEN_CMGS;
      SEG_TEXT: return LEN_TEXT;
      default:  return 1;
    endcase
  endfunction

  function automatic logic [7:0] msg_byte(input seg_e seg, input logic [IDX_W-1:0] idx,
                                          input logic [2:0] src);
    int i;
    int body;
    int sh;
    logic [7:0] b;
    i    = int'(idx);
    body = seg_len(seg) - ((seg == SEG_TEXT) ? 1 : 2);
    sh   = 8 * (body - 1 - i);
    b    = 8'h00;
    if (i < body) begin
      case (seg)
        SEG_AT:   b = 8'(STR_AT >> sh);
        SEG_CMGF: b = 8'(STR_CMGF >> sh);
        SEG_CSMP: b = 8'(STR_CSMP >> sh);
        SEG_CSCS: b = 8'(STR_CSCS >> sh);
        SEG_CMGS: b = 8'(STR_CMGS >> sh);
        SEG_TEXT: begin
          case (src)
            3'd1:    b = 8'(STR_TEXT1 >> sh);
            3'd2:    b = 8'(STR_TEXT2 >> sh);
            default: b = 8'(STR_TEXT0 >> sh);
          endcase
        end
        default:  b = 8'h00;
      endcase
    end else if (seg == SEG_TEXT) begin
      if (i == body) b = 8'h1A;
    end else if (i == body) begin
      b = 8'h0D;
    end else if (i == body + 1) begin
      b = 8'h0A;
    end
    return b;
  endfunction

endpackage

// File: rtl/gsm_msg_rom.sv
// Registered message lookup: (segment, index, source) -> byte plus last-byte flag.
// Output only updates when en is high, so it holds the byte through SEND/WAIT_DONE.
module gsm_msg_rom
  import gsm_at_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [2:0]       seg,
  input  logic [IDX_W-1:0] idx,
  input  logic [2:0]       src,
  output logic [7:0]       data,
  output logic             last
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data <= 8'h00;
      last <= 1'b0;
    end else if (en) begin
      data <= msg_byte(seg_e'(seg), idx, src);
      last <= (int'(idx) == seg_len(seg_e'(seg)) - 1);
    end
  end

endmodule

// File: rtl/gsm_at_sequencer.sv
// Sends a fixed AT-command SMS session over a byte UART for each alarm trigger edge,
// serving pending sources lowest index first with inter-byte and inter-command gaps.
module gsm_at_sequencer
  import gsm_at_pkg::*;
#(
  parameter int N_SRC      = 3,
  parameter int BYTE_GAP   = 16,
  parameter int CMD_GAP    = 60000,
  parameter int TX_TIMEOUT = 1000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_SRC-1:0] trig,
  input  logic             tx_done,
  output logic             tx_enable,
  output logic [7:0]       tx_data,
  output logic             busy,
  output logic [2:0]       active_src,
  output logic             msg_done,
  output logic             tx_err
);

  localparam int MAX_GAP = (BYTE_GAP > CMD_GAP) ? BYTE_GAP : CMD_GAP;
  localparam int MAX_CNT = (TX_TIMEOUT > MAX_GAP) ? TX_TIMEOUT : MAX_GAP;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);

  logic [N_SRC-1:0] sync1_reg, sync2_reg, sync3_reg;
  logic [N_SRC-1:0] pending_reg, pending_next;
  logic [N_SRC-1:0] rise;
  state_e           state_reg, state_next;
  seg_e             seg_reg, seg_next;
  logic [IDX_W-1:0] idx_reg, idx_next;
  logic [2:0]       src_reg, src_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             en_reg, en_next;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;
  logic             err_reg, err_next;
  logic [2:0]       pick;
  logic             rom_last;

  // sync3 is the edge-detect history behind the two synchroniser stages
  assign rise = sync2_reg & ~sync3_reg;

  always_comb begin
    pick = 3'd0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (pending_reg[i]) pick = 3'(i);
    end
  end

  always_comb begin
    state_next   = state_reg;
    pending_next = pending_reg;
    seg_next     = seg_reg;
    idx_next     = idx_reg;
    src_next     = src_reg;
    cnt_next     = cnt_reg;
    en_next      = en_reg;
    busy_next    = busy_reg;
    done_next    = 1'b0;
    err_next     = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (|pending_reg) begin
          state_next   = ST_LOAD;
          src_next     = pick;
          pending_next = pending_reg & ~(N_SRC'(1) << pick);
          busy_next    = 1'b1;
          seg_next     = SEG_AT;
          idx_next     = '0;
          cnt_next     = '0;
        end
      end
      ST_LOAD: begin
        state_next = ST_SEND;
        en_next    = 1'b1;
        cnt_next   = '0;
      end
      ST_SEND: begin
        state_next = ST_WAIT_DONE;
        cnt_next   = cnt_reg + 1'b1;
      end
      ST_WAIT_DONE: begin
        // The timeout counter started in SEND so tx_enable stays high exactly TX_TIMEOUT clocks
        if (tx_done) begin
          en_next  = 1'b0;
          cnt_next = '0;
          if (!rom_last)              state_next = ST_BYTE_GAP;
          else if (seg_reg == SEG_TEXT) state_next = ST_FINISH;
          else                        state_next = ST_CMD_GAP;
        end else if (cnt_reg == CNT_W'(TX_TIMEOUT - 1)) begin
          state_next = ST_IDLE;
          en_next    = 1'b0;
          err_next   = 1'b1;
          busy_next  = 1'b0;
          src_next   = 3'd0;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      ST_BYTE_GAP: begin
        if (cnt_reg == CNT_W'(BYTE_GAP - 1)) begin
          state_next = ST_LOAD;
          idx_next   = idx_reg + 1'b1;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      ST_CMD_GAP: begin
        if (cnt_reg == CNT_W'(CMD_GAP - 1)) begin
          state_next = ST_LOAD;
          seg_next   = seg_e'(seg_reg + 3'd1);
          idx_next   = '0;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      ST_FINISH: begin
        state_next = ST_IDLE;
        done_next  = 1'b1;
        busy_next  = 1'b0;
        src_next   = 3'd0;
      end
      default: state_next = ST_IDLE;
    endcase

    // New edges win over the clear above, so a re-trigger of the served source queues again
    pending_next = pending_next | rise;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg   <= '0;
      sync2_reg   <= '0;
      sync3_reg   <= '0;
      pending_reg <= '0;
      state_reg   <= ST_IDLE;
      seg_reg     <= SEG_AT;
      idx_reg     <= '0;
      src_reg     <= 3'd0;
      cnt_reg     <= '0;
      en_reg      <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      sync1_reg   <= trig;
      sync2_reg   <= sync1_reg;
      sync3_reg   <= sync2_reg;
      pending_reg <= pending_next;
      state_reg   <= state_next;
      seg_reg     <= seg_next;
      idx_reg     <= idx_next;
      src_reg     <= src_next;
      cnt_reg     <= cnt_next;
      en_reg      <= en_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
      err_reg     <= err_next;
    end
  end

  gsm_msg_rom u_rom (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (state_reg == ST_LOAD),
    .seg   (seg_reg),
    .idx   (idx_reg),
    .src   (src_reg),
    .data  (tx_data),
    .last  (rom_last)
  );

  assign tx_enable  = en_reg;
  assign busy       = busy_reg;
  assign active_src = src_reg;
  assign msg_done   = done_reg;
  assign tx_err     = err_reg;

endmodule

// File: tb/tb_gsm_at_sequencer.sv
// Scoreboard bench: each triggered session queues its expected bytes, a monitor checks
// every byte request (data, source, preceding gap) as the sequencer emits it.
module tb_gsm_at_sequencer;

  localparam int N_SRC      = 3;
  localparam int BYTE_GAP   = 4;
  localparam int CMD_GAP    = 10;
  localparam int TX_TIMEOUT = 50;
  localparam int SESSION    = 149;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] trig = 3'b000;
  logic       tx_done = 1'b0;
  logic       tx_enable;
  logic [7:0] tx_data;
  logic       busy;
  logic [2:0] active_src;
  logic       msg_done;
  logic       tx_err;

  always #5 clk = ~clk;

  gsm_at_sequencer #(
    .N_SRC      (N_SRC),
    .BYTE_GAP   (BYTE_GAP),
    .CMD_GAP    (CMD_GAP),
    .TX_TIMEOUT (TX_TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .trig       (trig),
    .tx_done    (tx_done),
    .tx_enable  (tx_enable),
    .tx_data    (tx_data),
    .busy       (busy),
    .active_src (active_src),
    .msg_done   (msg_done),
    .tx_err     (tx_err)
  );

  typedef struct {
    bit         care;
    logic [7:0] val;
    logic [2:0] src;
    int         gap;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   byte_cnt = 0;
  int   done_cnt = 0;
  int   err_cnt = 0;
  bit   silent = 1'b0;
  bit   stray = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Segment ends (exclusive byte offsets) of AT, CMGF, CSMP, CSCS, CMGS; TEXT ends at 149
  function automatic void push_session(input logic [2:0] src);
    int   ends [5] = '{4, 15, 36, 52, 108};
    exp_t e;
    for (int k = 0; k < SESSION; k++) begin
      e.care = 1'b0;
      e.val  = 8'h00;
      e.src  = src;
      e.gap  = (k == 0) ? -1 : BYTE_GAP + 1;
      if (k == 0) begin e.care = 1'b1; e.val = 8'h41; end
      if (k == 1) begin e.care = 1'b1; e.val = 8'h54; end
      for (int s = 0; s < 5; s++) begin
        if (k == ends[s] - 2) begin e.care = 1'b1; e.val = 8'h0D; end
        if (k == ends[s] - 1) begin e.care = 1'b1; e.val = 8'h0A; end
        if (k == ends[s]) e.gap = CMD_GAP + 1;
      end
      if (k == SESSION - 1) begin e.care = 1'b1; e.val = 8'h1A; end
      exp_q.push_back(e);
    end
  endfunction

  // UART model: tx_done in the third cycle of tx_enable; optional stray pulse in a gap
  initial begin
    int hi;
    int lo;
    hi = 0;
    lo = 0;
    forever begin
      @(posedge clk);
      #1;
      tx_done = 1'b0;
      if (tx_enable) begin hi++; lo = 0; end
      else begin lo++; hi = 0; end
      if (tx_enable && hi == 3 && !silent) tx_done = 1'b1;
      if (!tx_enable && lo == 2 && stray) tx_done = 1'b1;
    end
  end

  // Monitor: pops one expected entry per tx_enable rising edge
  initial begin
    bit         prev;
    int         low;
    logic [7:0] cap;
    exp_t       e;
    prev = 1'b0;
    low  = 0;
    cap  = 8'h00;
    forever begin
      @(negedge clk);
      if (tx_enable && !prev) begin
        byte_cnt++;
        check("exp_queue_nonempty", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          $display("[TB] byte %0d src %0d data %02h gap %0d", byte_cnt, active_src, tx_data, low);
          if (e.care) check("tx_data", tx_data, e.val);
          check("active_src", active_src, e.src);
          if (e.gap > 0) check("gap_clocks", low, e.gap);
        end
        cap = tx_data;
        low = 0;
      end
      if (tx_enable && tx_done) check("tx_data_stable", tx_data, cap);
      if (!tx_enable) low++;
      if (msg_done) begin
        done_cnt++;
        $display("[TB] msg_done #%0d", done_cnt);
      end
      if (tx_err) begin
        err_cnt++;
        $display("[TB] tx_err #%0d", err_cnt);
      end
      prev = tx_enable;
    end
  end

  task automatic pulse_trig(input logic [2:0] v);
    @(negedge clk);
    trig = v;
    repeat (3) @(negedge clk);
    trig = 3'b000;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(n < budget), 1);
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_bytes(input string name, input int target, input int budget);
    int n;
    n = 0;
    while (byte_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(n < budget), 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tx_enable"}, tx_enable, 0);
    check({tag, "_tx_data"}, tx_data, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_active_src"}, active_src, 0);
    check({tag, "_msg_done"}, msg_done, 0);
    check({tag, "_tx_err"}, tx_err, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got %0d bytes, expected completion", byte_cnt);
    $fatal(1, "watchdog");
  end

  initial begin
    int   b0, d0, e0, n, h;
    exp_t e;

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single session on source 0
    b0 = byte_cnt; d0 = done_cnt; e0 = err_cnt;
    push_session(3'd0);
    pulse_trig(3'b001);
    wait_idle("t1_complete", 5000);
    check("t1_bytes", byte_cnt - b0, SESSION);
    check("t1_msg_done", done_cnt - d0, 1);
    check("t1_tx_err", err_cnt - e0, 0);
    check("t1_busy", busy, 0);
    check("t1_active_src", active_src, 0);

    // Simultaneous triggers on 0 and 2: lowest first
    b0 = byte_cnt; d0 = done_cnt;
    push_session(3'd0);
    push_session(3'd2);
    pulse_trig(3'b101);
    wait_idle("t2_complete", 10000);
    check("t2_bytes", byte_cnt - b0, 2 * SESSION);
    check("t2_msg_done", done_cnt - d0, 2);
    check("t2_busy", busy, 0);

    // Silent UART: timeout aborts after TX_TIMEOUT clocks of tx_enable
    b0 = byte_cnt; d0 = done_cnt; e0 = err_cnt;
    silent = 1'b1;
    e.care = 1'b1; e.val = 8'h41; e.src = 3'd0; e.gap = -1;
    exp_q.push_back(e);
    pulse_trig(3'b001);
    n = 0;
    while (!tx_enable && n < 200) begin @(negedge clk); n++; end
    check("t3_enable_rose", tx_enable, 1);
    h = 0;
    while (tx_enable && h < 200) begin h++; @(negedge clk); end
    check("t3_enable_high_clocks", h, TX_TIMEOUT);
    wait_idle("t3_idle", 200);
    repeat (20) @(negedge clk);
    check("t3_tx_err", err_cnt - e0, 1);
    check("t3_msg_done", done_cnt - d0, 0);
    check("t3_bytes", byte_cnt - b0, 1);
    check("t3_busy", busy, 0);
    silent = 1'b0;

    // Re-trigger of the served source during CSMP queues exactly one more session
    b0 = byte_cnt; d0 = done_cnt;
    push_session(3'd1);
    push_session(3'd1);
    pulse_trig(3'b010);
    wait_bytes("t4_reach_csmp", b0 + 20, 3000);
    pulse_trig(3'b010);
    wait_idle("t4_complete", 10000);
    check("t4_bytes", byte_cnt - b0, 2 * SESSION);
    check("t4_msg_done", done_cnt - d0, 2);

    // Asynchronous reset mid-session at byte 60
    b0 = byte_cnt;
    push_session(3'd0);
    pulse_trig(3'b001);
    wait_bytes("t5_reach_byte60", b0 + 60, 3000);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("t5_async");
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    b0 = byte_cnt;
    repeat (300) @(negedge clk);
    check("t5_no_restart_bytes", byte_cnt - b0, 0);
    check("t5_busy", busy, 0);
    check("t5_tx_enable", tx_enable, 0);

    // Stray tx_done in gaps must not disturb count or timing
    b0 = byte_cnt; d0 = done_cnt;
    stray = 1'b1;
    push_session(3'd2);
    pulse_trig(3'b100);
    wait_idle("t6_complete", 5000);
    stray = 1'b0;
    check("t6_bytes", byte_cnt - b0, SESSION);
    check("t6_msg_done", done_cnt - d0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
